// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode constants, ALUOp encodings and the
// control bundle passed from the decoder to the decode stage.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CBZ is identified by an 8-bit prefix; the low opcode bits are immediate.
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       rt_as_read2;  // Read2 comes from Rt [4:0] instead of Rm
        logic       reads_read2;  // Read2 is a real source operand
    } decode_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  read1;
        logic [4:0]  read2;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic [1:0]  alu_op;
        logic [10:0] opcode;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } stage_reg_t;

endpackage

// File: rtl/legv8_decoder.sv
// Purely combinational LEGv8 opcode decoder: instruction word in, control
// bundle and illegal-opcode flag out.
module legv8_decoder
    import legv8_pkg::*;
(
    input  logic [31:0]  instr,
    output decode_ctrl_t ctrl,
    output logic         illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ctrl    = '0;
        illegal = 1'b0;
        if (instr[31:24] == OP_CBZ) begin
            ctrl.branch      = 1'b1;
            ctrl.alu_op      = ALUOP_CBZ;
            ctrl.rt_as_read2 = 1'b1;
            ctrl.reads_read2 = 1'b1;
        end else begin
            case (instr[31:21])
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.alu_op      = ALUOP_RTYPE;
                    ctrl.reads_read2 = 1'b1;
                end
                OP_LDUR: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_op    = ALUOP_MEM;
                end
                OP_STUR: begin
                    ctrl.mem_write   = 1'b1;
                    ctrl.alu_op      = ALUOP_MEM;
                    ctrl.rt_as_read2 = 1'b1;
                    ctrl.reads_read2 = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered LEGv8 decode stage with valid/ready input, stall/flush and
// optional load-use bubble insertion (enabled by `INSTR_DECODE_HAZARD_EN).
module instr_decode_stage
    import legv8_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [4:0]  Read1,
    output logic [4:0]  Read2,
    output logic [4:0]  WriteReg,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic [10:0] Opcode,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        illegal_instr
);

    decode_ctrl_t ctrl;
    logic         dec_illegal;
    logic [4:0]   src2;
    logic         hazard;
    stage_reg_t   stage_q;
    stage_reg_t   stage_d;
    stage_reg_t   decoded;

    legv8_decoder u_decoder (
        .instr   (instr),
        .ctrl    (ctrl),
        .illegal (dec_illegal)
    );

    assign src2 = ctrl.rt_as_read2 ? instr[4:0] : instr[20:16];

`ifdef INSTR_DECODE_HAZARD_EN
    logic load_pending;
    // XZR is hard-wired zero, so a load targeting it can never feed a consumer.
    assign load_pending = stage_q.valid & stage_q.mem_read & (stage_q.write_reg != 5'd31);
    assign hazard = instr_valid & load_pending &
                    ((instr[9:5] == stage_q.write_reg) |
                     (ctrl.reads_read2 & (src2 == stage_q.write_reg)));
`else
    assign hazard = 1'b0;
`endif

    assign instr_ready = reset_n & (flush | (~stall & ~hazard));

    always_comb begin
        decoded           = '0;
        decoded.valid     = 1'b1;
        decoded.read1     = instr[9:5];
        decoded.read2     = src2;
        decoded.write_reg = instr[4:0];
        decoded.reg_write = ctrl.reg_write;
        decoded.alu_op    = ctrl.alu_op;
        decoded.opcode    = instr[31:21];
        decoded.mem_read  = ctrl.mem_read;
        decoded.mem_write = ctrl.mem_write;
        decoded.branch    = ctrl.branch;
    end

    always_comb begin
        stage_d = '0;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            // Held contents stay, but the illegal flag is a one-cycle pulse.
            stage_d         = stage_q;
            stage_d.illegal = 1'b0;
        end else if (hazard) begin
            stage_d = '0;
        end else if (instr_valid) begin
            if (dec_illegal) begin
                stage_d.illegal = 1'b1;
            end else begin
                stage_d = decoded;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples its inputs from before the edge.
            stage_q <= stage_d;
        end
    end

    assign out_valid     = stage_q.valid;
    assign Read1         = stage_q.read1;
    assign Read2         = stage_q.read2;
    assign WriteReg      = stage_q.write_reg;
    assign RegWrite      = stage_q.reg_write;
    assign ALUOp         = stage_q.alu_op;
    assign Opcode        = stage_q.opcode;
    assign MemRead       = stage_q.mem_read;
    assign MemWrite      = stage_q.mem_write;
    assign Branch        = stage_q.branch;
    assign illegal_instr = stage_q.illegal;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered LEGv8 decode stage sitting directly upstream of the register-file/ALU execute block. Accepts one 32-bit instruction per cycle over a valid/ready handshake, decodes it into register indices and execute controls (Read1, Read2, WriteReg, RegWrite, ALUOp, Opcode, plus memory/branch controls), and holds them in a single output register that drives the next stage. Inserts a one-cycle bubble on a load-use hazard and supports external stall and flush.

## Interface
- No parameters. Widths are fixed by the LEGv8 ISA.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr_valid  in  1  upstream instruction valid
- instr  in  32  instruction word
- instr_ready  out  1  stage accepts `instr` this cycle (combinational)
- stall  in  1  hold the output register and refuse input
- flush  in  1  kill the output register contents and drop the incoming instruction
- out_valid  out  1  output register holds a real instruction
- Read1  out  5  Rn field `[9:5]`
- Read2  out  5  Rm `[20:16]` for R-type; Rt `[4:0]` for STUR/CBZ
- WriteReg  out  5  Rd/Rt `[4:0]`
- RegWrite  out  1  write-back enable
- ALUOp  out  2  00 load/store, 01 CBZ, 10 R-type
- Opcode  out  11  `instr[31:21]`
- MemRead, MemWrite, Branch  out  1 each  memory and branch controls
- illegal_instr  out  1  registered single-cycle flag for an unrecognised opcode

## Operation
- Decoded opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: R-type, RegWrite=1, ALUOp=10.
  - LDUR 11111000010: RegWrite=1, MemRead=1, ALUOp=00.
  - STUR 11111000000: MemWrite=1, ALUOp=00.
  - CBZ `instr[31:24]`=10110100: Branch=1, ALUOp=01.
- Bubble: every output is 0, including out_valid.
- Per-cycle priority is flush > stall > hazard > accept.
- **flush**
  - instr_ready=1, so the presented instruction is consumed and dropped.
  - The output register loads a bubble.
- **stall**
  - instr_ready=0.
  - The output register holds.
- **hazard**: all of the following hold.
  - The output register holds an LDUR with out_valid=1 and WriteReg≠31.
  - The incoming valid instruction reads that register: Read1 always; Read2 only for R-type, STUR and CBZ.
  - Response: instr_ready=0 and the output register loads a bubble.
  - The same instruction is accepted the following cycle.
- **accept**
  - instr_valid & instr_ready: the decoded fields are registered.
  - instr_valid=0 with instr_ready=1: a bubble is registered.
- **illegal opcode**
  - The instruction is consumed and a bubble is registered.
  - illegal_instr=1 for exactly one cycle.
- Opcode is always `instr[31:21]` for accepted legal instructions; 0 in a bubble.

## Timing
- Latency is 1 cycle from accepting handshake to registered outputs.
- Throughput is 1 instruction/cycle without hazards.
- instr_ready is combinational from stall, flush, instr, and the output register.
- Reset (asynchronous, mid-operation included): all outputs 0, out_valid=0, illegal_instr=0.
  - instr_ready is driven to 0 while reset_n=0.
  - It follows the normal rules from the first edge after release.
- flush and stall asserted together: flush wins, producing a bubble with no hold.
- A hazard under stall: stall governs, the output holds, and no bubble is inserted until stall drops.
- XZR (31) is never a hazard source.

## Configuration
- Macro: `INSTR_DECODE_HAZARD_EN`.
- Defined: load-use detection and bubble insertion as above.
- Undefined:
  - The hazard term is constant 0.
  - instr_ready = !stall | flush.
  - Software scheduling is required.

## Structure
- Shared package `legv8_pkg` holds:
  - Opcode constants (OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ).
  - ALUOp encodings (ALUOP_MEM, ALUOP_CBZ, ALUOP_RTYPE).
  - A packed `decode_ctrl_t` struct holding the control bits.
- One combinational sub-module, `legv8_decoder`: instruction in, `decode_ctrl_t` plus the illegal flag out.
- The top holds the output register, the handshake, and the hazard logic.

## Test plan
1. **Reset and R-type:** reset, then ADD X3,X1,X2 (0x8B020023) with valid.
   - Next cycle: Read1=1, Read2=2, WriteReg=3, RegWrite=1, ALUOp=10, Opcode=0x458, out_valid=1.
2. **Load-use:** LDUR X5,[X1] (0xF8400025), then ADD X6,X5,X2 (0x8B0200A6).
   - One bubble cycle with instr_ready=0; the ADD is then accepted with Read1=5.
   - With the macro undefined: no bubble.
3. **Store and CBZ field selection:**
   - STUR: Read2=Rt, MemWrite=1.
   - CBZ X7 (0xB4000007): Read2=7, Branch=1, ALUOp=01, RegWrite=0.
4. **Stall and flush:**
   - stall held 3 cycles: outputs frozen, instr_ready=0.
   - flush together with stall: bubble next cycle, instruction dropped.
5. **Illegal opcode:** instr 0x00000000 → illegal_instr=1 for one cycle, out_valid=0, and the stage accepts the next instruction normally.
6. **Reset mid-stream:** reset_n asserted asynchronously between edges → outputs 0 immediately, and decode resumes cleanly after release.
